bsram_arbiter: RTL

BSRAM_ARBITER -- requirements
Module: bsram_arbiter

---
 rtl/bsram_arb_pkg.sv | 31 +++
 rtl/bsram_arbiter_if.sv | 49 ++++
 rtl/bsram_arb_grant.sv | 49 ++++
 rtl/bsram_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bsram_arb_pkg.sv
// Shared types and constants for the BSRAM arbiter: FSM states,
// requester indices, the full-word byte mask and the byte-merge helper.
package bsram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        RMW_WR,
        ACK
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_idx_e;

    localparam logic [3:0] FULL_MASK = 4'hF;

    // Replace the bytes of old_word whose mask bit is set with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[i*8 +: 8] = mask[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/bsram_arbiter_if.sv
// Bus bundle between the two requesters (cpu, dbg), the arbiter and the BSRAM.
// The arbiter connects through the slave modport; the environment through master.
interface bsram_arbiter_if #(
    parameter int ADDRESS_SIZE   = 15,
    parameter int RAM_ADDR_WIDTH = 11
);
    logic                      cpu_req;
    logic                      cpu_write;
    logic [ADDRESS_SIZE-1:0]   cpu_addr;
    logic [31:0]               cpu_wdata;
    logic [3:0]                cpu_wmask;
    logic                      cpu_ready;
    logic [31:0]               cpu_rdata;

    logic                      dbg_req;
    logic                      dbg_write;
    logic [ADDRESS_SIZE-1:0]   dbg_addr;
    logic [31:0]               dbg_wdata;
    logic [3:0]                dbg_wmask;
    logic                      dbg_ready;
    logic [31:0]               dbg_rdata;

    logic                      ram_ce;
    logic                      ram_oce;
    logic                      ram_wre;
    logic [RAM_ADDR_WIDTH-1:0] ram_ad;
    logic [31:0]               ram_din;
    logic [31:0]               ram_dout;
    logic                      ram_reset;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata, cpu_wmask,
        output cpu_ready, cpu_rdata,
        input  dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_wmask,
        output dbg_ready, dbg_rdata,
        output ram_ce, ram_oce, ram_wre, ram_ad, ram_din, ram_reset,
        input  ram_dout
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata, cpu_wmask,
        input  cpu_ready, cpu_rdata,
        output dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_wmask,
        input  dbg_ready, dbg_rdata,
        input  ram_ce, ram_oce, ram_wre, ram_ad, ram_din, ram_reset,
        output ram_dout
    );

endinterface

// File: rtl/bsram_arb_grant.sv
// Grant selection between cpu and dbg.
// BSRAM_ARB_ROUND_ROBIN_EN defined: a tie goes to the requester not granted
// last, tracked by a last-grant register. Undefined: dbg always wins a tie
// and no register exists.
module bsram_arb_grant
    import bsram_arb_pkg::*;
(
`ifdef BSRAM_ARB_ROUND_ROBIN_EN
    input  logic     clock,
    input  logic     reset_n,
    input  logic     i_take,
`endif
    input  logic     i_cpu_req,
    input  logic     i_dbg_req,
    output logic     o_valid,
    output req_idx_e o_sel
);

    assign o_valid = i_cpu_req | i_dbg_req;

`ifdef BSRAM_ARB_ROUND_ROBIN_EN
    req_idx_e r_last;

    // Remember who was granted most recently so a tie can be handed to the other side.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= REQ_CPU;
        end else if (i_take && o_valid) begin
            r_last <= o_sel;
        end
    end

    // Single requester wins outright; a tie alternates away from the last grant.
    always_comb begin
        o_sel = REQ_CPU;
        if (i_cpu_req && i_dbg_req) begin
            o_sel = (r_last == REQ_DBG) ? REQ_CPU : REQ_DBG;
        end else if (i_dbg_req) begin
            o_sel = REQ_DBG;
        end
    end
`else
    // Fixed priority: dbg beats cpu whenever both ask.
    always_comb begin
        o_sel = i_dbg_req ? REQ_DBG : REQ_CPU;
    end
`endif

endmodule

// File: rtl/bsram_arbiter.sv
// Two-port (cpu, dbg) arbiter in front of a single-port BSRAM with a
// 2-cycle read latency. Partial writes are done as read-modify-write.
// Optional feature macro: BSRAM_ARB_ROUND_ROBIN_EN (round-robin tie break).
module bsram_arbiter
    import bsram_arb_pkg::*;
#(
    parameter int ADDRESS_SIZE   = 15,
    parameter int RAM_ADDR_WIDTH = 11
)(
    input  logic           clock,
    input  logic           reset_n,
    bsram_arbiter_if.slave bus
);

    arb_state_e                r_state;
    arb_state_e                w_next;
    req_idx_e                  r_sel;
    logic                      r_write;
    logic [RAM_ADDR_WIDTH-1:0] r_ad;
    logic [31:0]               r_wdata;
    logic [3:0]                r_wmask;
    logic [31:0]               r_merge;

    logic                      w_valid;
    logic                      w_start;
    req_idx_e                  w_sel;
    logic                      w_in_write;
    logic [ADDRESS_SIZE-1:0]   w_in_addr;
    logic [31:0]               w_in_wdata;
    logic [3:0]                w_in_wmask;
    logic                      w_in_oor;
    logic [RAM_ADDR_WIDTH-1:0] w_in_word;

    logic                      w_ce;
    logic                      w_oce;
    logic                      w_wre;
    logic [RAM_ADDR_WIDTH-1:0] w_ad;
    logic [31:0]               w_din;
    logic                      w_ready;
    logic [31:0]               w_rdata;

`ifdef BSRAM_ARB_ROUND_ROBIN_EN
    logic w_take;
    assign w_take = (r_state == IDLE);
`endif

    bsram_arb_grant u_grant (
`ifdef BSRAM_ARB_ROUND_ROBIN_EN
        .clock     (clock),
        .reset_n   (reset_n),
        .i_take    (w_take),
`endif
        .i_cpu_req (bus.cpu_req),
        .i_dbg_req (bus.dbg_req),
        .o_valid   (w_valid),
        .o_sel     (w_sel)
    );

    // Route the winning requester's fields; an address is out of range when
    // any bit above the BSRAM word address plus byte offset is set.
    assign w_in_write = (w_sel == REQ_DBG) ? bus.dbg_write : bus.cpu_write;
    assign w_in_addr  = (w_sel == REQ_DBG) ? bus.dbg_addr  : bus.cpu_addr;
    assign w_in_wdata = (w_sel == REQ_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
    assign w_in_wmask = (w_sel == REQ_DBG) ? bus.dbg_wmask : bus.cpu_wmask;
    assign w_in_oor   = |(w_in_addr >> (RAM_ADDR_WIDTH + 2));
    assign w_in_word  = w_in_addr[RAM_ADDR_WIDTH+1:2];
    assign w_start    = w_valid & reset_n;

    // State register; reset aborts whatever access was in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the winner only in IDLE so the request stays fixed for the whole access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sel   <= REQ_CPU;
            r_write <= 1'b0;
            r_ad    <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (r_state == IDLE && w_valid) begin
            r_sel   <= w_sel;
            r_write <= w_in_write;
            r_ad    <= w_in_word;
            r_wdata <= w_in_wdata;
            r_wmask <= w_in_wmask;
        end
    end

    // Build the read-modify-write word once the old word arrives from the BSRAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_merge <= '0;
        end else if (r_state == RD_DONE && r_write) begin
            r_merge <= merge_bytes(bus.ram_dout, r_wdata, r_wmask);
        end
    end

    // Next state and BSRAM/requester strobes; IDLE issues the first access combinationally.
    always_comb begin
        w_next  = r_state;
        w_ce    = 1'b0;
        w_oce   = 1'b0;
        w_wre   = 1'b0;
        w_ad    = r_ad;
        w_din   = '0;
        w_ready = 1'b0;
        w_rdata = '0;
        case (r_state)
            IDLE: begin
                w_ad = '0;
                if (w_start) begin
                    w_ad = w_in_word;
                    if (w_in_oor || (w_in_write && w_in_wmask == 4'h0)) begin
                        w_next = ACK;
                    end else if (w_in_write && w_in_wmask == FULL_MASK) begin
                        w_ce   = 1'b1;
                        w_wre  = 1'b1;
                        w_din  = w_in_wdata;
                        w_next = ACK;
                    end else begin
                        w_ce   = 1'b1;
                        w_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                w_oce  = 1'b1;
                w_next = RD_DONE;
            end
            RD_DONE: begin
                if (r_write) begin
                    w_next = RMW_WR;
                end else begin
                    w_ready = 1'b1;
                    w_rdata = bus.ram_dout;
                    w_next  = IDLE;
                end
            end
            RMW_WR: begin
                w_ce    = 1'b1;
                w_wre   = 1'b1;
                w_din   = r_merge;
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            ACK: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.ram_ce    = w_ce;
    assign bus.ram_oce   = w_oce;
    assign bus.ram_wre   = w_wre;
    assign bus.ram_ad    = w_ad;
    assign bus.ram_din   = w_din;
    assign bus.ram_reset = ~reset_n;

    assign bus.cpu_ready = w_ready && (r_sel == REQ_CPU);
    assign bus.dbg_ready = w_ready && (r_sel == REQ_DBG);
    assign bus.cpu_rdata = (r_sel == REQ_CPU) ? w_rdata : 32'h0;
    assign bus.dbg_rdata = (r_sel == REQ_DBG) ? w_rdata : 32'h0;

endmodule
